// File: rtl/imem_arbiter.sv
// imem_arbiter: boot/run sequencing and single-port arbitration for the
// instruction memory bank. The loader owns the port during BOOT; in RUN the
// fetch stage has priority, except that the loader is forced a slot after
// STARVE_MAX consecutive contested fetch grants. Read data returns one cycle
// after the grant through registered outputs.
module imem_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int DEPTH      = 256,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,

    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    input  logic              ld_done,
    output logic              ld_gnt,
    output logic              ld_rvalid,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              ld_err,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              cpu_stall,
    output logic              boot_done
);

    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0]  STARVE_LIM = CNT_W'(STARVE_MAX);
    localparam logic [ADDR_W:0]   DEPTH_LIM  = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [0:0] {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [CNT_W-1:0]  r_starve_cnt;
    logic [CNT_W-1:0]  w_starve_next;

    logic              w_if_gnt;
    logic              w_ld_gnt;
    logic              w_if_in_range;
    logic              w_ld_in_range;

    logic              r_if_rvalid;
    logic              r_if_err;
    logic [DATA_W-1:0] r_if_rdata;
    logic              r_ld_rvalid;
    logic              r_ld_err;
    logic [DATA_W-1:0] r_ld_rdata;

    // Address range decode; the extra MSB keeps the compare unsigned and lossless.
    assign w_if_in_range = ({1'b0, if_addr} < DEPTH_LIM);
    assign w_ld_in_range = ({1'b0, ld_addr} < DEPTH_LIM);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and grant decision; nothing is granted while reset is held.
    always_comb begin
        w_next_state = r_state;
        w_if_gnt     = 1'b0;
        w_ld_gnt     = 1'b0;
        if (!rst_n) begin
            w_next_state = ST_BOOT;
        end else begin
            case (r_state)
                ST_BOOT: begin
                    w_ld_gnt = ld_req;
                    if (ld_done) begin
                        w_next_state = ST_RUN;
                    end else begin
                        w_next_state = ST_BOOT;
                    end
                end
                ST_RUN: begin
                    w_next_state = ST_RUN;
                    if (if_req && ld_req) begin
                        if (r_starve_cnt == STARVE_LIM) begin
                            w_ld_gnt = 1'b1;
                        end else begin
                            w_if_gnt = 1'b1;
                        end
                    end else begin
                        w_if_gnt = if_req;
                        w_ld_gnt = ld_req;
                    end
                end
                default: begin
                    w_next_state = ST_BOOT;
                end
            endcase
        end
    end

    // Starvation counter update: counts fetch wins while the loader waits.
    always_comb begin
        w_starve_next = r_starve_cnt;
        if (w_ld_gnt) begin
            w_starve_next = {CNT_W{1'b0}};
        end else if (w_if_gnt && ld_req && (r_starve_cnt != STARVE_LIM)) begin
            w_starve_next = r_starve_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            w_starve_next = r_starve_cnt;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= {CNT_W{1'b0}};
        end else begin
            r_starve_cnt <= w_starve_next;
        end
    end

    // Fetch return path: valid/err pulse one cycle after grant, data held until next return.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_if_rvalid <= 1'b0;
            r_if_err    <= 1'b0;
            r_if_rdata  <= {DATA_W{1'b0}};
        end else begin
            r_if_rvalid <= w_if_gnt;
            r_if_err    <= w_if_gnt & ~w_if_in_range;
            if (w_if_gnt) begin
                r_if_rdata <= w_if_in_range ? mem_rdata : {DATA_W{1'b0}};
            end else begin
                r_if_rdata <= r_if_rdata;
            end
        end
    end

    // Loader return path: reads return data, writes only report range errors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ld_rvalid <= 1'b0;
            r_ld_err    <= 1'b0;
            r_ld_rdata  <= {DATA_W{1'b0}};
        end else begin
            r_ld_rvalid <= w_ld_gnt & ~ld_we;
            r_ld_err    <= w_ld_gnt & ~w_ld_in_range;
            if (w_ld_gnt && !ld_we) begin
                r_ld_rdata <= w_ld_in_range ? mem_rdata : {DATA_W{1'b0}};
            end else begin
                r_ld_rdata <= r_ld_rdata;
            end
        end
    end

    // Memory port steering; enables are suppressed for out-of-range addresses.
    assign mem_addr  = w_ld_gnt ? ld_addr : if_addr;
    assign mem_wdata = w_ld_gnt ? ld_wdata : {DATA_W{1'b0}};
    assign mem_read  = (w_if_gnt & w_if_in_range) |
                       (w_ld_gnt & ~ld_we & w_ld_in_range);
    assign mem_write = w_ld_gnt & ld_we & w_ld_in_range;

    assign if_gnt    = w_if_gnt;
    assign ld_gnt    = w_ld_gnt;
    assign if_rvalid = r_if_rvalid;
    assign if_err    = r_if_err;
    assign if_rdata  = r_if_rdata;
    assign ld_rvalid = r_ld_rvalid;
    assign ld_err    = r_ld_err;
    assign ld_rdata  = r_ld_rdata;

    assign boot_done = (r_state == ST_RUN);
    assign cpu_stall = (r_state == ST_BOOT) ? 1'b1 : (if_req & ~w_if_gnt);

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: a behavioural model checks every cycle at the
// falling edge, and directed scenarios add hand-computed literal checks.
module tb_imem_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int DEPTH = 256;
    localparam int SMAX = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_gnt, if_rvalid, if_err;
    logic [DW-1:0] if_rdata;
    logic          ld_req = 1'b0, ld_we = 1'b0, ld_done = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_wdata = '0;
    logic          ld_gnt, ld_rvalid, ld_err;
    logic [DW-1:0] ld_rdata;
    logic          mem_read, mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          cpu_stall, boot_done;

    int checks = 0;
    int errors = 0;

    imem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_done(ld_done), .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid),
        .ld_rdata(ld_rdata), .ld_err(ld_err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .cpu_stall(cpu_stall), .boot_done(boot_done)
    );

    always #5 clk = ~clk;

    // Memory bank seen by the DUT: combinational read, write on rising edge.
    logic [DW-1:0] bank [DEPTH];
    assign mem_rdata = (mem_addr < AW'(DEPTH)) ? bank[mem_addr[7:0]] : '0;
    always @(posedge clk) begin
        if (mem_write) bank[mem_addr[7:0]] <= mem_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: what the arbiter must have done, kept in plain terms.
    bit            m_run = 0;
    int            m_streak = 0;       // contested fetch wins since last loader grant
    bit            m_if_v = 0, m_if_e = 0, m_ld_v = 0, m_ld_e = 0;
    logic [DW-1:0] m_if_d = '0, m_ld_d = '0;
    logic [DW-1:0] gold [DEPTH];

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            bank[i] = '0;
            gold[i] = '0;
        end
    end

    // Per-cycle compare against the model, then advance the model across the next edge.
    always @(negedge clk) begin
        bit e_if, e_ld, if_ok, ld_ok;
        if (!rst_n) begin
            m_run = 0; m_streak = 0;
            m_if_v = 0; m_if_e = 0; m_ld_v = 0; m_ld_e = 0;
            m_if_d = '0; m_ld_d = '0;
            chk("rst_if_rvalid", 32'(if_rvalid), 32'd0);
            chk("rst_ld_rvalid", 32'(ld_rvalid), 32'd0);
            chk("rst_if_err", 32'(if_err), 32'd0);
            chk("rst_ld_err", 32'(ld_err), 32'd0);
            chk("rst_if_rdata", 32'(if_rdata), 32'd0);
            chk("rst_ld_rdata", 32'(ld_rdata), 32'd0);
            chk("rst_boot_done", 32'(boot_done), 32'd0);
            chk("rst_cpu_stall", 32'(cpu_stall), 32'd1);
            chk("rst_mem_read", 32'(mem_read), 32'd0);
            chk("rst_mem_write", 32'(mem_write), 32'd0);
            chk("rst_if_gnt", 32'(if_gnt), 32'd0);
        end else begin
            chk("if_rvalid", 32'(if_rvalid), 32'(m_if_v));
            chk("if_err", 32'(if_err), 32'(m_if_e));
            chk("if_rdata", 32'(if_rdata), 32'(m_if_d));
            chk("ld_rvalid", 32'(ld_rvalid), 32'(m_ld_v));
            chk("ld_err", 32'(ld_err), 32'(m_ld_e));
            chk("ld_rdata", 32'(ld_rdata), 32'(m_ld_d));

            e_if = 0; e_ld = 0;
            if (!m_run) e_ld = ld_req;
            else if (if_req && ld_req) begin
                if (m_streak >= SMAX) e_ld = 1; else e_if = 1;
            end else begin
                e_if = if_req; e_ld = ld_req;
            end
            if_ok = (int'(if_addr) < DEPTH);
            ld_ok = (int'(ld_addr) < DEPTH);

            chk("if_gnt", 32'(if_gnt), 32'(e_if));
            chk("ld_gnt", 32'(ld_gnt), 32'(e_ld));
            chk("mem_read", 32'(mem_read), 32'((e_if && if_ok) || (e_ld && !ld_we && ld_ok)));
            chk("mem_write", 32'(mem_write), 32'(e_ld && ld_we && ld_ok));
            chk("mem_addr", 32'(mem_addr), 32'(e_ld ? ld_addr : if_addr));
            if (e_ld && ld_we) chk("mem_wdata", 32'(mem_wdata), 32'(ld_wdata));
            chk("cpu_stall", 32'(cpu_stall), 32'(!m_run || (if_req && !e_if)));
            chk("boot_done", 32'(boot_done), 32'(m_run));

            m_if_v = e_if;
            m_if_e = e_if && !if_ok;
            if (e_if) m_if_d = if_ok ? gold[if_addr[7:0]] : '0;
            m_ld_v = e_ld && !ld_we;
            m_ld_e = e_ld && !ld_ok;
            if (e_ld && !ld_we) m_ld_d = ld_ok ? gold[ld_addr[7:0]] : '0;
            if (e_ld && ld_we && ld_ok) gold[ld_addr[7:0]] = ld_wdata;
            if (e_ld) m_streak = 0;
            else if (e_if && ld_req && m_streak < SMAX) m_streak = m_streak + 1;
            if (!m_run && ld_done) m_run = 1;
        end
    end

    // One cycle of stimulus: drive after the rising edge, return just after the falling edge.
    task automatic cyc(input bit ir, input logic [AW-1:0] ia, input bit lr, input bit lw,
                       input logic [AW-1:0] la, input logic [DW-1:0] lwd, input bit ld);
        @(posedge clk); #1;
        if_req = ir; if_addr = ia;
        ld_req = lr; ld_we = lw; ld_addr = la; ld_wdata = lwd; ld_done = ld;
        @(negedge clk); #1;
    endtask

    task automatic idle();
        cyc(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0);
    endtask

    string seq;

    initial begin
        // Reset / boot
        if_req = 1'b1;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        cyc(1, 16'h0003, 0, 0, 16'h0000, 16'h0000, 0);
        chk("boot_stall", 32'(cpu_stall), 32'd1);
        chk("boot_if_gnt", 32'(if_gnt), 32'd0);
        chk("boot_done0", 32'(boot_done), 32'd0);

        // Load then run (ld_done in the same cycle as the last write)
        cyc(0, 16'h0000, 1, 1, 16'h0000, 16'h2010, 0);
        chk("boot_ld_gnt", 32'(ld_gnt), 32'd1);
        cyc(0, 16'h0000, 1, 1, 16'h0001, 16'h8D4A, 1);
        chk("done_cycle_boot", 32'(boot_done), 32'd0);
        cyc(1, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0);
        chk("run_boot_done", 32'(boot_done), 32'd1);
        chk("run_if_gnt", 32'(if_gnt), 32'd1);
        cyc(1, 16'h0001, 0, 0, 16'h0000, 16'h0000, 1);
        chk("fetch0_valid", 32'(if_rvalid), 32'd1);
        chk("fetch0_data", 32'(if_rdata), 32'h2010);
        idle();
        chk("fetch1_data", 32'(if_rdata), 32'h8D4A);
        chk("ld_done_ignored", 32'(boot_done), 32'd1);

        // Contention: fetch addr 0 vs loader read addr 1
        seq = "";
        for (int i = 0; i < 10; i++) begin
            cyc(1, 16'h0000, 1, 0, 16'h0001, 16'h0000, 0);
            seq = {seq, if_gnt ? "F" : (ld_gnt ? "L" : "-")};
        end
        checks++;
        if (seq != "FFFFLFFFFL") begin
            errors++;
            $display("FAIL contention_seq: got %s expected FFFFLFFFFL", seq);
        end
        idle();

        // Out-of-range loader read and write
        cyc(0, 16'h0000, 1, 0, 16'h0100, 16'h0000, 0);
        chk("oor_rd_gnt", 32'(ld_gnt), 32'd1);
        chk("oor_rd_mem_read", 32'(mem_read), 32'd0);
        cyc(0, 16'h0000, 1, 1, 16'hFFFF, 16'h1234, 0);
        chk("oor_rd_valid", 32'(ld_rvalid), 32'd1);
        chk("oor_rd_err", 32'(ld_err), 32'd1);
        chk("oor_rd_data", 32'(ld_rdata), 32'h0000);
        chk("oor_wr_mem_write", 32'(mem_write), 32'd0);
        idle();
        chk("oor_wr_err", 32'(ld_err), 32'd1);
        chk("oor_wr_no_valid", 32'(ld_rvalid), 32'd0);

        // Out-of-range fetch
        cyc(1, 16'h0200, 0, 0, 16'h0000, 16'h0000, 0);
        idle();
        chk("oor_if_err", 32'(if_err), 32'd1);
        chk("oor_if_data", 32'(if_rdata), 32'h0000);

        // Write then read same address
        cyc(0, 16'h0000, 1, 1, 16'h0005, 16'hABCD, 0);
        cyc(1, 16'h0005, 0, 0, 16'h0000, 16'h0000, 0);
        idle();
        chk("wr_rd_data", 32'(if_rdata), 32'hABCD);

        // Reset asserted mid-access
        cyc(1, 16'h0001, 0, 0, 16'h0000, 16'h0000, 0);
        chk("mid_if_gnt", 32'(if_gnt), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rvalid", 32'(if_rvalid), 32'd0);
        @(negedge clk); #1;
        chk("mid_rst_rvalid2", 32'(if_rvalid), 32'd0);
        chk("mid_rst_boot", 32'(boot_done), 32'd0);
        rst_n = 1'b1;
        cyc(1, 16'h0001, 0, 0, 16'h0000, 16'h0000, 0);
        chk("after_rst_gnt", 32'(if_gnt), 32'd0);
        chk("after_rst_stall", 32'(cpu_stall), 32'd1);
        chk("after_rst_rvalid", 32'(if_rvalid), 32'd0);
        idle();
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Sequencing and arbitration controller for the 256×16 instruction memory bank. After reset it gives a program loader exclusive access so it can fill the memory. It then shares the single memory port between the CPU fetch stage and the loader/debug port. Read data is registered, and requesters see a fixed one-cycle return latency.

## Interface
- `ADDR_W`, default 16: address width of all ports.
- `DATA_W`, default 16: instruction word width.
- `DEPTH`, default 256: number of implemented words; addresses ≥ `DEPTH` are out of range.
- `STARVE_MAX`, default 4: maximum number of consecutive contested fetch grants before the loader is forced a slot.
- Ports:
  - `clk`  in  1  sole clock; all state updates on the rising edge.
  - `rst_n`  in  1  reset, asynchronous assert, active-low.
  - `if_req`  in  1  fetch read request.
  - `if_addr`  in  `ADDR_W`  fetch address.
  - `if_gnt`  out  1  fetch granted this cycle (combinational).
  - `if_rvalid`  out  1  fetch data valid, one cycle after grant.
  - `if_rdata`  out  `DATA_W`  fetch data.
  - `if_err`  out  1  out-of-range fetch, aligned with `if_rvalid`.
  - `ld_req`  in  1  loader request.
  - `ld_we`  in  1  loader write (1) or read (0).
  - `ld_addr`  in  `ADDR_W`  loader address.
  - `ld_wdata`  in  `DATA_W`  loader write data.
  - `ld_done`  in  1  pulse ending boot load.
  - `ld_gnt`  out  1  loader granted this cycle (combinational).
  - `ld_rvalid`  out  1  loader read data valid.
  - `ld_rdata`  out  `DATA_W`  loader read data.
  - `ld_err`  out  1  out-of-range loader access.
  - `mem_read`  out  1  memory read enable.
  - `mem_write`  out  1  memory write enable; the memory writes on the rising edge.
  - `mem_addr`  out  `ADDR_W`  memory address.
  - `mem_wdata`  out  `DATA_W`  memory write data.
  - `mem_rdata`  in  `DATA_W`  memory read data, combinational from `mem_addr`.
  - `cpu_stall`  out  1  fetch blocked this cycle.
  - `boot_done`  out  1  high in RUN state.

## Operation
- The FSM has two states, BOOT and RUN. Reset enters BOOT.
- **BOOT**
  - `if_gnt`=0 and `cpu_stall`=1.
  - `ld_req` is granted whenever asserted.
  - `ld_done`=1 moves the FSM to RUN at the next edge; the request present in that same cycle is still serviced.
- **RUN**
  - A lone requester is granted.
  - If both request, fetch wins unless `starve_cnt`==`STARVE_MAX`, in which case the loader wins.
  - `ld_done` is ignored in RUN.
  - RUN exits only through reset.
- **`starve_cnt`**
  - Increments, saturating at `STARVE_MAX`, on each fetch grant while `ld_req`=1.
  - Clears to 0 on any loader grant.
  - Otherwise holds.
- **`cpu_stall`** = `if_req` & ~`if_gnt` in RUN.
- **Memory port**
  - `mem_addr` and `mem_wdata` follow the granted requester; with no grant they take fetch values.
  - `mem_read` = grant & read & in-range.
  - `mem_write` = `ld_gnt` & `ld_we` & in-range.
  - Reads and writes never occur in the same cycle.
- **Read return**
  - On a read grant, `mem_rdata` is registered (0 if out of range) into the winner's `rdata`.
  - The winner's `rvalid` is asserted for exactly one cycle.
  - `rdata` holds its value until the next read return.
- **Writes** produce no `rvalid`.
- **Out-of-range** (address ≥ `DEPTH`)
  - The access is granted and the memory enable is suppressed.
  - The `err` pulse is asserted one cycle later; for reads it coincides with `rvalid` and `rdata`=0.
  - For out-of-range writes only `err` pulses.
- **Back-to-back access**: a write followed by a read of the same address returns the new data.

## Timing
- Grant is combinational in the request cycle. Read data and valid appear at the next edge, giving a latency of 1 cycle.
- Throughput is one access per cycle total.
- Reset values:
  - state=BOOT, `starve_cnt`=0.
  - `if_rvalid`, `ld_rvalid`, `if_err`, `ld_err`, `boot_done` = 0.
  - `if_rdata`, `ld_rdata` = 0.
  - `cpu_stall`=1 (BOOT).
  - `mem_read` and `mem_write` = 0 while `rst_n`=0.
- Reset asserted mid-access drops any pending `rvalid` or `err` immediately; nothing is returned after reset.
- `ld_done` and `ld_req` in the same BOOT cycle: the request is serviced and RUN is entered at the next edge.
- With `STARVE_MAX`=4 and continuous contention, the pattern is 4 fetch grants, 1 loader grant, repeating.

## Test plan
- **Reset/boot**: hold `rst_n`=0, then release with `if_req`=1. `cpu_stall`=1, `if_gnt`=0, `boot_done`=0, all valids 0.
- **Load then run**:
  - Loader writes 0x2010 to address 0 and 0x8D4A to address 1, then pulses `ld_done`.
  - Fetch of address 0 then address 1 gives `if_gnt` in the same cycle and `if_rvalid` the next cycle, with `if_rdata`=0x2010 then 0x8D4A.
  - `boot_done`=1 from the cycle after `ld_done`.
- **Contention**: in RUN, hold `if_req`=1 and `ld_req`=1 (reads) for 10 cycles. Grants are F,F,F,F,L,F,F,F,F,L; `starve_cnt` returns to 0 after each L.
- **Out-of-range**: loader read of address 0x0100 gives `mem_read`=0, `ld_rvalid`=1 and `ld_err`=1 the next cycle, `ld_rdata`=0x0000. A loader write to 0xFFFF gives `mem_write`=0 and an `ld_err` pulse only.
- **Write-then-read**: in RUN, loader writes 0xABCD to address 5, then fetches address 5 in the next cycle. `if_rdata`=0xABCD.
- **Reset mid-access**: grant a fetch, then assert `rst_n`=0 before the edge. `if_rvalid` stays 0 and the FSM is back in BOOT.
